ysyx_22041461_mul_iter: RTL and testbench
=========================================

YSYX_22041461_MUL_ITER -- requirements
Module: ysyx_22041461_mul_iter

Interface
REQ-001 SHALL have parameter XLEN, 64, operand and result width (even, >=32).
REQ-002 SHALL have port clk input 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n input 1, reset, synchronous and active-low.
REQ-004 SHALL have port in_valid input 1, request valid.
REQ-005 SHALL have port in_ready output 1, unit can accept a request.
REQ-006 SHALL have port src1 input XLEN, multiplicand.
REQ-007 SHALL have port src2 input XLEN, multiplier.
REQ-008 SHALL have port ctrl_ALU input 5, operation code.
REQ-009 SHALL have port flush input 1, kill the in-flight operation.
REQ-010 SHALL have port out_valid output 1, result valid.
REQ-011 SHALL have port out_ready input 1, consumer accepts result.
REQ-012 SHALL have port MUL_out output XLEN, result.

Function
REQ-013 SHALL support these ops:
- 5'b01100 MULW: low 32 bits of src1[31:0]*src2[31:0], sign-extended to XLEN.
- 5'b01101 MULHU: upper XLEN bits, unsigned x unsigned.
- 5'b01110 MULHSU: upper XLEN bits, signed src1 x unsigned src2.
- 5'b01111 MULH: upper XLEN bits, signed x signed.
- 5'b10000 MUL: lower XLEN bits.
REQ-014 SHALL implement FSM states IDLE, BUSY, FIXUP, DONE; in_ready = (state==IDLE) && !flush.
REQ-015 SHALL, on handshake (in_valid && in_ready), latch operand magnitudes, result-sign flag and op, load step counter N, and go to BUSY.
REQ-016 SHALL retire one multiplier bit per BUSY cycle (shift-add into a 2*XLEN accumulator); N = XLEN, or 32 for MULW.
REQ-017 SHALL go BUSY -> FIXUP after N BUSY cycles; FIXUP conditionally two's-complement-negates the 2*XLEN product and selects the output field; FIXUP -> DONE.
REQ-018 SHALL assert out_valid only in DONE, with handshake in cycle 0 and out_valid first visible in cycle N+2 (66 for MUL with XLEN=64).
REQ-019 SHALL hold MUL_out and out_valid stable in DONE until out_ready; DONE -> IDLE on out_valid && out_ready.
REQ-020 SHALL accept an unsupported ctrl_ALU, go directly to DONE, and return 0.
REQ-021 SHALL handle the most-negative operand: MULH of two minimum values yields 2^(2*XLEN-2), computed without overflow.
REQ-022 SHALL make flush in any state force IDLE on the next edge with no result produced; flush overrides a same-cycle in_valid and a same-cycle out_ready.
REQ-023 SHALL drive MUL_out to 0 whenever out_valid is low.

Reset
REQ-024 SHALL, with rst_n low at a rising edge, enter IDLE, clear counter and accumulator, and drive out_valid=0, MUL_out=0, and in_ready=1 from the next cycle.
REQ-025 SHALL abandon any operation mid-flight on reset, with no result emitted.

Configuration
REQ-026 SHALL honour macro YSYX_22041461_MUL_RADIX4_EN: when defined, 2 bits per BUSY cycle (0/1/2/3 x multiplicand add) and N = XLEN/2 (16 for MULW); when undefined, the radix-2 behaviour of REQ-016; results identical in both builds.

Structure
REQ-027 SHALL place op-code constants, the FSM state enum and N-selection constants in package ysyx_22041461_mul_pkg.
REQ-028 SHALL use one combinational sub-module, ysyx_22041461_mul_step (accumulator + partial-product add/shift for one BUSY cycle, radix selected by macro).

Verification
REQ-029 SHALL cover MUL with src1=3 and src2=5: MUL_out=15, out_valid at cycle 66 (radix-2), 34 (radix-4).
REQ-030 SHALL cover MULHU with both operands all-ones: MUL_out=0xFFFF_FFFF_FFFF_FFFE; MULH with both operands all-ones: MUL_out=0.
REQ-031 SHALL cover MULHSU with src1=-1 and src2=2: MUL_out=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 SHALL cover MULW with src1=0x8000_0000 and src2=1: MUL_out=0xFFFF_FFFF_8000_0000, out_valid at cycle 34 (radix-2).
REQ-033 SHALL cover flush at BUSY cycle 10: no out_valid, in_ready=1 next cycle; a following MUL 2x2 returns 4.
REQ-034 SHALL cover out_ready low for 5 DONE cycles (MUL_out stable, in_ready=0), and rst_n low mid-BUSY (IDLE, out_valid never asserted).

Source files
------------

// File: rtl/ysyx_22041461_mul_pkg.sv
// Shared definitions for the iterative multiplier: op codes, FSM states and
// the helper that picks the BUSY cycle count.
// Build option: YSYX_22041461_MUL_RADIX4_EN retires two multiplier bits per
// BUSY cycle instead of one.
package ysyx_22041461_mul_pkg;

  localparam logic [4:0] OP_MULW   = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_MULHSU = 5'b01110;
  localparam logic [4:0] OP_MULH   = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;

  // MULW multiplies only the low word of each operand.
  localparam int W_OP_BITS = 32;

`ifdef YSYX_22041461_MUL_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
`else
  localparam int BITS_PER_STEP = 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mul_state_e;

  // Number of BUSY cycles needed to consume all multiplier bits.
  function automatic int n_steps(input int xlen, input logic is_w);
    return (is_w ? W_OP_BITS : xlen) / BITS_PER_STEP;
  endfunction

endpackage

// File: rtl/ysyx_22041461_mul_step.sv
// One BUSY cycle of the shift-add multiplier: adds the partial product
// selected by the low multiplier bit(s) and shifts both operands.
// Radix is chosen by YSYX_22041461_MUL_RADIX4_EN.
module ysyx_22041461_mul_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] mcand_o,
  output logic [XLEN-1:0]   mplier_o
);

  logic [2*XLEN-1:0] pp;

`ifdef YSYX_22041461_MUL_RADIX4_EN
  // Pick 0/1/2/3 times the multiplicand from the low two multiplier bits.
  always_comb begin
    case (mplier_i[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = mcand_i;
      2'd2:    pp = mcand_i << 1;
      default: pp = mcand_i + (mcand_i << 1);
    endcase
  end

  assign mcand_o  = mcand_i << 2;
  assign mplier_o = mplier_i >> 2;
`else
  // Pick 0 or 1 times the multiplicand from the low multiplier bit.
  always_comb begin
    pp = mplier_i[0] ? mcand_i : '0;
  end

  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;
`endif

  assign acc_o = acc_i + pp;

endmodule

// File: rtl/ysyx_22041461_mul_iter.sv
// Iterative multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Operands are multiplied as magnitudes; the sign is reapplied in FIXUP.
// Build option: YSYX_22041461_MUL_RADIX4_EN halves the BUSY cycle count.
module ysyx_22041461_mul_iter
  import ysyx_22041461_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      ctrl_ALU,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] MUL_out
);

  localparam int CNT_W = $clog2(XLEN + 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        op_q, op_d;
  logic              neg_q, neg_d;

  logic [2*XLEN-1:0] acc_step, mcand_step;
  logic [XLEN-1:0]   mplier_step;
  logic [2*XLEN-1:0] prod;

  logic              s1_signed, s2_signed, is_w, supported;
  logic [XLEN-1:0]   a_mag, b_mag;

  ysyx_22041461_mul_step #(.XLEN(XLEN)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_step),
    .mcand_o  (mcand_step),
    .mplier_o (mplier_step)
  );

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign MUL_out   = out_valid ? result_q : '0;

  // Undo the magnitude trick: negate the full product when the signs differ.
  assign prod = neg_q ? -acc_q : acc_q;

  // Decode the incoming op into signedness and operand magnitudes.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    is_w      = 1'b0;
    supported = 1'b1;
    case (ctrl_ALU)
      OP_MULW:          is_w = 1'b1;
      OP_MULHSU:        s1_signed = 1'b1;
      OP_MULH: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      OP_MULHU, OP_MUL: ;
      default:          supported = 1'b0;
    endcase

    a_mag = src1;
    b_mag = src2;
    if (is_w) begin
      // Only the low word matters and its low 32 product bits ignore sign.
      a_mag = {{(XLEN-32){1'b0}}, src1[31:0]};
      b_mag = {{(XLEN-32){1'b0}}, src2[31:0]};
    end else begin
      // The most-negative value maps to 2^(XLEN-1), which still fits unsigned.
      if (s1_signed && src1[XLEN-1]) a_mag = -src1;
      if (s2_signed && src2[XLEN-1]) b_mag = -src2;
    end
  end

  // Next-state and datapath updates; flush wins over every other event.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d     = ctrl_ALU;
            neg_d    = (s1_signed & src1[XLEN-1]) ^ (s2_signed & src2[XLEN-1]);
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CNT_W'(n_steps(XLEN, is_w));
            result_d = '0;
            state_d  = supported ? BUSY : DONE;
          end
        end
        BUSY: begin
          acc_d    = acc_step;
          mcand_d  = mcand_step;
          mplier_d = mplier_step;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIXUP;
        end
        FIXUP: begin
          case (op_q)
            OP_MULW: result_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
            OP_MUL:  result_d = prod[XLEN-1:0];
            default: result_d = prod[2*XLEN-1:XLEN];
          endcase
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset too, so a killed operation never leaves a
    // stale accumulator or result behind.
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_mul_iter.sv
// Self-checking bench for ysyx_22041461_mul_iter (XLEN=64).
// Results come from a 128-bit arithmetic reference model; latency from the
// step count implied by the radix build option.
module tb_ysyx_22041461_mul_iter;

  localparam int XLEN = 64;

`ifdef YSYX_22041461_MUL_RADIX4_EN
  localparam int BITS = 2;
`else
  localparam int BITS = 1;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      ctrl_ALU;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] MUL_out;

  int vectors;
  int miscompares;

  ysyx_22041461_mul_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .ctrl_ALU  (ctrl_ALU),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .MUL_out   (MUL_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain wide arithmetic.
  function automatic logic [63:0] ref_mul(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] ua, ub, sa, sb, p;
    logic [63:0]  pw;
    ua = {64'b0, a};
    ub = {64'b0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    p  = '0;
    case (op)
      5'b01100: begin
        pw = {32'b0, a[31:0]} * {32'b0, b[31:0]};
        return {{32{pw[31]}}, pw[31:0]};
      end
      5'b01101: begin p = ua * ub; return p[127:64]; end
      5'b01110: begin p = sa * ub; return p[127:64]; end
      5'b01111: begin p = sa * sb; return p[127:64]; end
      5'b10000: begin p = ua * ub; return p[63:0];   end
      default:  return 64'd0;
    endcase
  endfunction

  // Cycle (counted from the handshake cycle 0) in which out_valid appears.
  function automatic int exp_lat(input logic [4:0] op);
    if (op == 5'b01100) return 32 / BITS + 2;
    if (op inside {5'b01101, 5'b01110, 5'b01111, 5'b10000}) return XLEN / BITS + 2;
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] exp_v;
    int          lat;
    exp_v = ref_mul(op, a, b);
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    ctrl_ALU = op;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    ctrl_ALU = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat(op) != 1)
        check({tag, " out zero while busy"}, {63'(MUL_out != 0), out_valid}, 64'd0);
    end while (!out_valid && lat < 300);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(op)));
    check({tag, " result"}, MUL_out, exp_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held result"}, MUL_out, exp_v);
      check({tag, " held valid/ready"}, {62'd0, out_valid, in_ready}, 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " after accept"}, {61'd0, out_valid, in_ready, 1'(MUL_out != 0)}, 64'd2);
  endtask

  // Watch a window of cycles and report how many showed out_valid.
  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check({tag, " no out_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [4:0]  ops [6];
    logic [63:0] a, b;
    vectors     = 0;
    miscompares = 0;
    ops = '{5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b00011};

    rst_n = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0;
    ctrl_ALU = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset state", {MUL_out, 2'b00} >> 2 | {62'd0, out_valid, in_ready}, 64'd1);

    // Directed corner cases.
    run_op("mul 3x5", 5'b10000, 64'd3, 64'd5, 0);
    run_op("mulhu ones", 5'b01101, '1, '1, 0);
    run_op("mulh ones", 5'b01111, '1, '1, 0);
    run_op("mulhsu -1x2", 5'b01110, '1, 64'd2, 0);
    run_op("mulw min", 5'b01100, 64'h8000_0000, 64'd1, 0);
    run_op("mulh min*min", 5'b01111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op("mul hold5", 5'b10000, 64'hDEAD_BEEF, 64'h1234_5678_9ABC, 5);
    run_op("unsupported", 5'b00001, 64'd7, 64'd9, 1);

    // Flush in BUSY cycle 10.
    @(negedge clk);
    in_valid = 1'b1; ctrl_ALU = 5'b10000; src1 = 64'd11; src2 = 64'd13;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy -> idle", {62'd0, out_valid, in_ready}, 64'd1);
    watch_no_valid("flush busy", 80);
    run_op("mul 2x2 after flush", 5'b10000, 64'd2, 64'd2, 0);

    // Flush overrides a same-cycle request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; ctrl_ALU = 5'b10000; src1 = 64'd4; src2 = 64'd4;
    #1 check("flush blocks in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    watch_no_valid("flush idle", 80);

    // Reset in the middle of BUSY.
    @(negedge clk);
    in_valid = 1'b1; ctrl_ALU = 5'b01111; src1 = 64'd5; src2 = 64'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset mid busy", {62'd0, out_valid, in_ready}, 64'd1);
    watch_no_valid("reset mid busy", 80);

    // Randomized ops with corner-biased operands.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = '1;
        2:       a = 64'($urandom_range(0, 100));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       b = 64'h8000_0000_0000_0000;
        1:       b = {32'($urandom), 32'h8000_0000};
        2:       b = 64'($urandom_range(0, 100));
        default: b = {$urandom, $urandom};
      endcase
      run_op("random", ops[$urandom_range(0, 5)], a, b, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
